aes_inv_cipher_iter: RTL and testbench
======================================

# aes_inv_cipher_iter

Iterative AES-128 inverse cipher (FIPS-197 InvCipher). It is the decrypt-side counterpart of the encrypt pipeline and sits between the HPS-facing ciphertext input and the plaintext result path. The core accepts one 128-bit ciphertext block, runs the ten inverse rounds one per cycle, and presents the plaintext under a valid/ready handshake. It does not expand keys: each cycle it requests round keys by index from an external round-key store.

## Interface
- No parameters. AES-128 only: 10 rounds, fixed.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  ciphertext is present on `ciphertext`
- in_ready  out  1  core can accept a block
- ciphertext  in  128  input block
- rk_idx  out  4  round-key index requested this cycle (0..10)
- rk  in  128  round key `rk_idx`; combinational, valid in the same cycle
- out_valid  out  1  `plaintext_out` holds a result
- out_ready  in  1  consumer accepts the result
- plaintext_out  out  128  decrypted block
- busy  out  1  block in flight (all states except IDLE)

## Operation
- FSM states: IDLE, ROUND, FINAL, DONE.
- **IDLE**
  - `in_ready = 1` (forced 0 while `reset` is high).
  - `rk_idx = 10`.
  - On `in_valid && in_ready`: `st <= ciphertext ^ rk`, `rnd <= 9`, go to ROUND.
- **ROUND**
  - `rk_idx = rnd`.
  - `st <= InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ rk)`.
  - `rnd` decrements each cycle. When `rnd == 1`, go to FINAL.
- **FINAL**
  - `rk_idx = 0`.
  - `st <= InvSubBytes(InvShiftRows(st)) ^ rk`. InvMixColumns is skipped.
  - Go to DONE.
- **DONE**
  - `out_valid = 1`, `plaintext_out = st`.
  - Both are held stable until `out_ready`. On `out_valid && out_ready`, go to IDLE.
- `in_ready` is low outside IDLE. `in_valid` in those states is ignored and the data is not captured.
- `rk_idx` in DONE = 10, so it is ready for the next block.
- Byte order (no macro): byte 0 is `[127:120]`, FIPS-197 column-major. State column c occupies `[127-32c -: 32]`.
- Arithmetic: GF(2^8) with polynomial 0x11B. InvMixColumns uses coefficients {0e,0b,0d,09}, built from xtime chains. No multipliers are inferred.

## Timing
- Reset values:
  - FSM = IDLE, `st = 0`, `rnd = 0`.
  - `out_valid = 0`, `busy = 0`, `plaintext_out = 0`.
  - `rk_idx = 10`, `in_ready = 0` while reset is asserted.
- Latency: accept at edge T, then `out_valid = 1` in cycle T+11.
  - Cycles T+1..T+9 run rounds 9..1.
  - Cycle T+10 runs FINAL.
- Throughput:
  - With `out_ready` tied high, one block per 12 cycles (DONE→IDLE costs one cycle).
  - No overlap between blocks.
- Backpressure: DONE may last any number of cycles. `plaintext_out` is unchanged throughout.
- Reset mid-block (any state):
  - Next cycle is IDLE with all outputs at their reset values.
  - The in-flight block is discarded and no `out_valid` pulse occurs.
- `in_valid` high in the same cycle as the DONE handshake is not accepted. It is accepted one cycle later in IDLE.
- `rk` is sampled only on the edge of the cycle whose `rk_idx` requests it. The key store must present a stable `rk` for that cycle.

## Configuration
- Macro: `AES_INV_BYTESWAP_EN`.
- Defined:
  - `ciphertext` is byte-reversed on entry: HPS little-endian byte 0 at `[7:0]`.
  - `plaintext_out` is byte-reversed on exit.
  - `rk` is not swapped; the key store supplies FIPS order.
- Undefined: all ports are in FIPS order and no swap logic exists.

## Structure
- Package `aes_inv_pkg` holds:
  - the 256-entry `INV_SBOX` constant;
  - `NR = 10`;
  - FSM state enum `aes_inv_state_t`;
  - functions `xtime`, `gmul_9/b/d/e`, `inv_shift_rows`, `inv_sub_bytes`, `inv_mix_columns`.
- Sub-module `aes_inv_round` is purely combinational. Inputs are `st`, `rk` and `last`; output is the next state. `last` bypasses InvMixColumns.
- The top module holds the FSM, the round counter, the state register and the swap logic.

## Test plan
- **FIPS-197 C.1:**
  - Stimulus: key 000102…0f with bench-supplied round keys, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Response: `plaintext_out` = 00112233445566778899aabbccddeeff; `out_valid` at exactly T+11; `rk_idx` sequence 10,9,…,1,0.
- **FIPS-197 Appendix B:**
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, ciphertext 3925841d02dc09fbdc118597196a0b32.
  - Response: 3243f6a8885a308d313198a2e0370734.
- **Backpressure:**
  - Stimulus: hold `out_ready = 0` for 20 cycles after `out_valid`.
  - Response: `plaintext_out` stable; `in_ready = 0`; a second `in_valid` is ignored until after the handshake.
- **Reset mid-block:**
  - Stimulus: assert `reset` at round 5 for one cycle.
  - Response: next cycle IDLE, `busy = 0`, `out_valid = 0`, `plaintext_out = 0`; a fresh C.1 block then decrypts correctly.
- **Back-to-back:**
  - Stimulus: `out_ready = 1`, `in_valid = 1` continuously with the C.1 and B vectors alternating.
  - Response: results in order, spaced 12 cycles apart.
- **With `AES_INV_BYTESWAP_EN`:**
  - Stimulus: byte-reversed C.1 ciphertext 5ac5b47080b7cdd830047b6ad8e0c469.
  - Response: ffeeddccbbaa99887766554433221100.

Source files
------------

// File: rtl/aes_inv_pkg.sv
// rtl/aes_inv_pkg.sv - shared constants, state enum and GF(2^8) helpers for the AES-128 inverse cipher
package aes_inv_pkg;

    localparam int NR = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } aes_inv_state_t;

    localparam logic [7:0] INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Multiply by x modulo 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul_9(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] gmul_b(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] gmul_d(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] gmul_e(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    // Byte (row r, column c) sits at index 4c+r, MSB first; row r rotates right by r.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul_e(a0) ^ gmul_b(a1) ^ gmul_d(a2) ^ gmul_9(a3);
            o[119-32*c -: 8] = gmul_9(a0) ^ gmul_e(a1) ^ gmul_b(a2) ^ gmul_d(a3);
            o[111-32*c -: 8] = gmul_d(a0) ^ gmul_9(a1) ^ gmul_e(a2) ^ gmul_b(a3);
            o[103-32*c -: 8] = gmul_b(a0) ^ gmul_d(a1) ^ gmul_9(a2) ^ gmul_e(a3);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - one combinational AES inverse round; last skips InvMixColumns
module aes_inv_round
    import aes_inv_pkg::*;
(
    input  logic [127:0] st,
    input  logic [127:0] rk,
    input  logic         last,
    output logic [127:0] st_next
);

    logic [127:0] w_sub_key;

    // InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless this is the final round.
    always_comb begin
        w_sub_key = inv_sub_bytes(inv_shift_rows(st)) ^ rk;
        st_next   = last ? w_sub_key : inv_mix_columns(w_sub_key);
    end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// rtl/aes_inv_cipher_iter.sv - iterative AES-128 decrypt core, one round per cycle; optional AES_INV_BYTESWAP_EN
module aes_inv_cipher_iter
    import aes_inv_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ciphertext,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plaintext_out,
    output logic         busy
);

    aes_inv_state_t r_state;
    logic [127:0]   r_st;
    logic [3:0]     r_rnd;
    logic           r_out_valid;
    logic [127:0]   r_pt;

    logic [127:0]   w_ct;
    logic [127:0]   w_round_out;
    logic [127:0]   w_pt;

`ifdef AES_INV_BYTESWAP_EN
    // HPS side is little-endian: reverse byte order on the way in and out; keys stay in FIPS order.
    genvar g_i;
    for (g_i = 0; g_i < 16; g_i++) begin : g_swap
        assign w_ct[127-8*g_i -: 8] = ciphertext[8*g_i +: 8];
        assign w_pt[127-8*g_i -: 8] = w_round_out[8*g_i +: 8];
    end
`else
    assign w_ct = ciphertext;
    assign w_pt = w_round_out;
`endif

    aes_inv_round u_round (
        .st      (r_st),
        .rk      (rk),
        .last    (r_state == FINAL),
        .st_next (w_round_out)
    );

    assign in_ready      = (r_state == IDLE) && !reset;
    assign out_valid     = r_out_valid;
    assign plaintext_out = r_pt;
    assign busy          = (r_state != IDLE);

    // Round-key request: key 10 whenever idle or done so the next block's whitening key is already on rk.
    always_comb begin
        rk_idx = 4'(NR);
        if (!reset) begin
            case (r_state)
                ROUND:   rk_idx = r_rnd;
                FINAL:   rk_idx = 4'd0;
                default: rk_idx = 4'(NR);
            endcase
        end
    end

    // Control FSM, round counter, state register and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_st        <= '0;
            r_rnd       <= 4'd0;
            r_out_valid <= 1'b0;
            r_pt        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_st    <= w_ct ^ rk;
                        r_rnd   <= 4'(NR - 1);
                        r_state <= ROUND;
                    end
                end
                ROUND: begin
                    r_st  <= w_round_out;
                    r_rnd <= r_rnd - 4'd1;
                    if (r_rnd == 4'd1) begin
                        r_state <= FINAL;
                    end
                end
                FINAL: begin
                    r_st        <= w_round_out;
                    r_pt        <= w_pt;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// tb/tb_aes_inv_cipher_iter.sv - self-checking bench for aes_inv_cipher_iter
module tb_aes_inv_cipher_iter;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [127:0] ciphertext = '0;
    logic         in_ready;
    logic [3:0]   rk_idx;
    logic [127:0] rk;
    logic         out_valid;
    logic [127:0] plaintext_out;
    logic         busy;

    typedef struct {
        logic [127:0] ct;
        logic [127:0] pt;
        int           ksel;
    } vec_t;

    vec_t         vecs [2];
    logic [127:0] kstore [2][11];
    logic [7:0]   sbox [256];
    int           pres_sel = 0;
    int           act_sel = 0;
    logic [127:0] pres_pt = '0;
    logic [127:0] q_exp [$];
    int           q_acc [$];
    int           cyc = 0;
    int           n_cmp = 0;
    int           n_err = 0;
    int           last_hs = -1;
    bit           b2b = 1'b0;
    bit           prev_ov = 1'b0;

    aes_inv_cipher_iter dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .ciphertext    (ciphertext),
        .rk_idx        (rk_idx),
        .rk            (rk),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .plaintext_out (plaintext_out),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [127:0] swp(input logic [127:0] x);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = x[8*i +: 8];
        return r;
    endfunction

    // Key store model: while idle it serves the block being offered, otherwise the block in flight.
    always_comb begin
        rk = '0;
        if (rk_idx <= 4'd10) rk = kstore[in_ready ? pres_sel : act_sel][rk_idx];
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            q_exp.delete();
            q_acc.delete();
        end
    end

    // Scoreboard: push on acceptance, pop and compare on the output handshake.
    always @(negedge clk) begin
        if (!reset && in_valid && in_ready) begin
            q_exp.push_back(pres_pt);
            q_acc.push_back(cyc + 1);
            act_sel = pres_sel;
        end
        if (out_valid && !prev_ov && q_acc.size() > 0)
            chk("latency", 128'(cyc - q_acc[0]), 128'(10));
        if (out_valid && out_ready) begin
            if (q_exp.size() == 0) begin
                chk("unexpected_out", 128'(1), 128'(0));
            end else begin
                chk("plaintext", plaintext_out, q_exp.pop_front());
                void'(q_acc.pop_front());
            end
            if (b2b && last_hs >= 0) chk("b2b_spacing", 128'(cyc - last_hs), 128'(12));
            last_hs = cyc;
        end
        prev_ov = out_valid;
    end

    task automatic present(input int i);
        ciphertext = vecs[i].ct;
        pres_pt    = vecs[i].pt;
        pres_sel   = vecs[i].ksel;
        in_valid   = 1'b1;
    endtask

    task automatic wait_accept();
        bit got;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
        end
        if (!got) chk("accept_timeout", 128'(0), 128'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out();
        bit got;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (out_valid) got = 1'b1;
        end
        if (!got) chk("out_timeout", 128'(0), 128'(1));
    endtask

    task automatic run_one(input int i, input bit check_seq);
        present(i);
        wait_accept();
        in_valid = 1'b0;
        if (check_seq) begin
            for (int k = 0; k <= 10; k++) begin
                @(negedge clk);
                chk("rk_idx_seq", 128'(rk_idx), 128'((k <= 8) ? 9 - k : ((k == 9) ? 0 : 10)));
            end
        end else begin
            wait_out();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] keys [2];
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rcon;
        logic [7:0]   inv;
        logic [127:0] hold;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end

        keys[0] = 128'h000102030405060708090a0b0c0d0e0f;
        keys[1] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        for (int kk = 0; kk < 2; kk++) begin
            for (int i = 0; i < 4; i++) w[i] = keys[kk][127-32*i -: 32];
            rcon = 8'h01;
            for (int i = 4; i < 44; i++) begin
                t = w[i-1];
                if (i % 4 == 0) begin
                    t = {t[23:0], t[31:24]};
                    t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
                    t[31:24] = t[31:24] ^ rcon;
                    rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                end
                w[i] = w[i-4] ^ t;
            end
            for (int r = 0; r < 11; r++) kstore[kk][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end

        vecs[0] = '{ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a, pt: 128'h00112233445566778899aabbccddeeff, ksel: 0};
        vecs[1] = '{ct: 128'h3925841d02dc09fbdc118597196a0b32, pt: 128'h3243f6a8885a308d313198a2e0370734, ksel: 1};
`ifdef AES_INV_BYTESWAP_EN
        for (int i = 0; i < 2; i++) begin
            vecs[i].ct = swp(vecs[i].ct);
            vecs[i].pt = swp(vecs[i].pt);
        end
`endif

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_rk_idx", 128'(rk_idx), 128'(10));
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_plaintext", plaintext_out, 128'(0));
        chk("idle_in_ready", 128'(in_ready), 128'(1));
        chk("idle_rk_idx", 128'(rk_idx), 128'(10));
        @(posedge clk);
        #1;

        // Table-driven single blocks; C.1 also checks the key-index sequence
        for (int i = 0; i < 2; i++) run_one(i, i == 0);

        // Backpressure: hold the result, ignore a second block until the handshake
        out_ready = 1'b0;
        present(0);
        wait_accept();
        present(1);
        wait_out();
        hold = plaintext_out;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("bp_stable", plaintext_out, hold);
            chk("bp_in_ready", 128'(in_ready), 128'(0));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle_busy", 128'(busy), 128'(0));
        chk("bp_idle_in_ready", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_out();
        @(posedge clk);
        #1;

        // Reset in the middle of round 5
        present(0);
        wait_accept();
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_rk_idx5", 128'(rk_idx), 128'(5));
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("mid_busy", 128'(busy), 128'(0));
        chk("mid_out_valid", 128'(out_valid), 128'(0));
        chk("mid_plaintext", plaintext_out, 128'(0));
        chk("mid_rk_idx", 128'(rk_idx), 128'(10));
        @(posedge clk);
        #1;
        run_one(0, 1'b0);

        // Back-to-back, alternating vectors
        b2b = 1'b1;
        last_hs = -1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            present(i % 2);
            wait_accept();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 40 && q_exp.size() != 0; k++) @(negedge clk);
        b2b = 1'b0;
        chk("queue_drained", 128'(q_exp.size()), 128'(0));

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
